led_pattern_gen: RTL

//   Parametrised LED pattern engine replacing the fixed free-running LED counter.

---
 rtl/led_pattern_gen_if.sv | 9 +
 rtl/led_pattern_gen.sv | 95 +++++++++
 2 files changed

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: control inputs and LED outputs of the pattern engine
interface led_pattern_gen_if #(parameter int N_LEDS = 8);
  logic enable;
  logic [1:0] mode;
  logic [N_LEDS-1:0] leds;
  logic step_tick;
  modport master(output enable, mode, input leds, step_tick);
  modport slave(input enable, mode, output leds, step_tick);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: binary / scanner / breathing / off LED patterns stepped by a shared prescaler
module led_pattern_gen #(
  parameter int N_LEDS = 8,
  parameter int PRESCALE_W = 20,
  parameter int PWM_W = 8
) (
  input logic sys_clk,
  input logic sys_rst_n,
  led_pattern_gen_if.slave bus
);
  localparam int PW = $clog2(N_LEDS);
  typedef enum logic [1:0] {BINARY, SCANNER, BREATHE, OFF} mode_t;
  mode_t mode_q;
  logic [PRESCALE_W-1:0] presc, presc_d;
  logic [N_LEDS-1:0] cnt, cnt_d, leds_q, leds_d, pattern;
  logic [PW-1:0] pos, pos_d;
  logic up, up_d, lvl_up, lvl_up_d, step_q;
  logic [PWM_W-1:0] level, level_d, pwm_cnt, pwm_d;
  logic restart, tick, step;
  assign restart = bus.mode != mode_q;
  assign tick = bus.enable && (&presc);
  assign step = tick && !restart;
  assign pattern = mode_q == BINARY ? cnt :
                   mode_q == SCANNER ? N_LEDS'(1) << pos :
                   mode_q == BREATHE ? {N_LEDS{pwm_cnt < level}} : '0;
  assign bus.leds = leds_q;
  assign bus.step_tick = step_q;
  always_comb begin
    presc_d = presc;
    cnt_d = cnt;
    pos_d = pos;
    up_d = up;
    level_d = level;
    lvl_up_d = lvl_up;
    pwm_d = pwm_cnt;
    leds_d = bus.enable ? pattern : leds_q;
    if (restart) begin
      presc_d = '0;
      cnt_d = '0;
      pos_d = '0;
      up_d = 1'b1;
      level_d = '0;
      lvl_up_d = 1'b1;
      pwm_d = '0;
    end else if (bus.enable) begin
      presc_d = presc + 1'b1;
      pwm_d = pwm_cnt + 1'b1;
      if (tick) begin
        case (mode_q)
          BINARY: cnt_d = cnt + 1'b1;
          SCANNER: begin
            // end LEDs turn around in place so each is lit for a single step per sweep
            if (up) begin
              up_d = pos != PW'(N_LEDS - 1);
              pos_d = up_d ? pos + 1'b1 : PW'(N_LEDS - 2);
            end else begin
              up_d = pos == '0;
              pos_d = up_d ? PW'(1) : pos - 1'b1;
            end
          end
          BREATHE: begin
            level_d = lvl_up ? level + 1'b1 : level - 1'b1;
            lvl_up_d = lvl_up ? level_d != '1 : level_d == '0;
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q <= BINARY;
      presc <= '0;
      cnt <= '0;
      pos <= '0;
      up <= 1'b1;
      level <= '0;
      lvl_up <= 1'b1;
      pwm_cnt <= '0;
      leds_q <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_t'(bus.mode);
      presc <= presc_d;
      cnt <= cnt_d;
      pos <= pos_d;
      up <= up_d;
      level <= level_d;
      lvl_up <= lvl_up_d;
      pwm_cnt <= pwm_d;
      leds_q <= leds_d;
      step_q <= step;
    end
  end
endmodule
